counter_bus_arbiter: RTL

- Round-robin read scheduler for N counters sharing one tri-state data bus.
- Each counter drives the bus only while its read input is high.
- The arbiter guarantees at most one read is high at any time, and inserts idle turnaround cycles between bus owners, so the bus never contends (never X).
- Captures the bus value at the end of each read and returns it with the source index. Sits between the requesting logic and the counter read pins.

---
 rtl/counter_bus_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/counter_bus_arbiter.sv
// counter_bus_arbiter: round-robin read scheduler for N counters sharing one
// tri-state data bus. One read enable is high at a time, for HOLD cycles.
// Each grant is followed by TURN idle cycles so bus owners never overlap.
// The bus value is captured at the end of each read and returned with its source index.
module counter_bus_arbiter #(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int HOLD = 2,
  parameter int TURN = 1,
  parameter int IDW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [DW-1:0]   bus_data,
  output logic [N-1:0]    read,
  output logic            busy,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic [IDW-1:0]  rd_id,
  output logic [N-1:0]    done
);

  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int TCW = (TURN > 1) ? $clog2(TURN) : 1;
  localparam logic [N-1:0] ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_TURN} state_t;

  state_t           state;
  logic [HCW-1:0]   hold_cnt;
  logic [TCW-1:0]   turn_cnt;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   next_start;
  logic             arb_found;
  logic [IDW-1:0]   arb_grant;
  logic [IDW-1:0]   arb_next;
  int               idx_i;

  // Pick the first requester at or after next_start, wrapping around the index range.
  always_comb begin
    arb_found = 1'b0;
    arb_grant = '0;
    idx_i     = 0;
    for (int k = 0; k < N; k++) begin
      idx_i = int'(next_start) + k;
      if (idx_i >= N) idx_i = idx_i - N;
      if (!arb_found && req[idx_i[IDW-1:0]]) begin
        arb_found = 1'b1;
        arb_grant = idx_i[IDW-1:0];
      end
    end
    arb_next = (arb_grant == IDW'(N - 1)) ? '0 : arb_grant + 1'b1;
  end

  // Scheduler FSM: the state register, counters and every output are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      turn_cnt   <= '0;
      grant      <= '0;
      next_start <= '0;
      read       <= '0;
      busy       <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_id      <= '0;
      done       <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= '0;
      case (state)
        S_IDLE: begin
          if (arb_found) begin
            state      <= S_READ;
            busy       <= 1'b1;
            read       <= ONE << arb_grant;
            grant      <= arb_grant;
            next_start <= arb_next;
            hold_cnt   <= '0;
          end
        end
        S_READ: begin
          if (hold_cnt == HCW'(HOLD - 1)) begin
            read     <= '0;
            rd_data  <= bus_data;
            rd_id    <= grant;
            rd_valid <= 1'b1;
            done     <= ONE << grant;
            turn_cnt <= '0;
            state    <= S_TURN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_TURN: begin
          if (turn_cnt == TCW'(TURN - 1)) begin
            if (arb_found) begin
              state      <= S_READ;
              busy       <= 1'b1;
              read       <= ONE << arb_grant;
              grant      <= arb_grant;
              next_start <= arb_next;
              hold_cnt   <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          read  <= '0;
        end
      endcase
    end
  end

endmodule
